// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM bus widths and arbiter FSM state type
package ram_pkg;
    localparam int RAM_BUS_SIZE = 15;
    localparam int RAM_DATA_W   = 8;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
endpackage

// File: rtl/ram_rr_pick.sv
// ram_rr_pick: combinational 2-way round-robin pick
// req   - request vector {req1, req0}
// last  - requester granted most recently
// valid - any request present
// gnt   - index of the winning requester
module ram_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       gnt
);
    assign valid = |req;
    assign gnt   = (&req) ? ~last : req[1];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter for an asynchronous strobed RAM
// req/we/addr/wdata 0,1 - requester access (held until ack), ack0/ack1 - completion pulses
// rdata                 - data of the last completed read
// ram_addr/ram_wdata    - RAM address and write data, ram_wdata_oe - bus drive enable
// ram_rdata             - RAM data bus read back, ram_r/ram_w - RAM strobes
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_BUS_SIZE,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_r,
    output logic              ram_w
);
    state_t state, state_nx;
    logic   we_q, last_q, pick_valid, pick_gnt;

    ram_rr_pick u_pick (
        .req   ({req1, req0}),
        .last  (last_q),
        .valid (pick_valid),
        .gnt   (pick_gnt)
    );

    // Outputs decode from state only, so async reset forces them low at once.
    // last_q doubles as the current grant while an access is in flight.
    always_comb begin
        state_nx     = IDLE;
        ram_r        = 1'b0;
        ram_w        = 1'b0;
        ram_wdata_oe = we_q && state != IDLE;
        ack0         = state == HOLD && !last_q;
        ack1         = state == HOLD && last_q;
        case (state)
            IDLE:    state_nx = pick_valid ? SETUP : IDLE;
            SETUP:   state_nx = STROBE;
            STROBE: begin
                state_nx = HOLD;
                ram_w    = we_q;
                ram_r    = !we_q;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_valid) begin
                last_q    <= pick_gnt;
                we_q      <= pick_gnt ? we1 : we0;
                ram_addr  <= pick_gnt ? addr1 : addr0;
                ram_wdata <= pick_gnt ? wdata1 : wdata0;
            end
            if (state == STROBE && !we_q)
                rdata <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random scoreboard bench for ram_arbiter
module tb_ram_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, ram_wdata_oe, ram_r, ram_w;
    logic [7:0]  rdata, ram_wdata, ram_rdata;
    logic [14:0] ram_addr;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model[int];
    logic [7:0] mem[0:32767] = '{default: 8'h00};
    int         checks = 0, errors = 0;
    int         w_cnt = 0, r_cnt = 0;
    bit         oe_rd = 0;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
        .ram_rdata(ram_rdata), .ram_r(ram_r), .ram_w(ram_w)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge ram_w) mem[ram_addr] = ram_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (ram_w) w_cnt++;
        if (ram_r) r_cnt++;
        if (ram_wdata_oe) oe_rd = 1;
        chk("strobe_overlap", {31'b0, ram_r & ram_w}, 0);
        chk("oe_with_r", {31'b0, ram_wdata_oe & ram_r}, 0);
        if (ram_w) chk("oe_with_w", {31'b0, ram_wdata_oe}, 1);
    end

    task automatic access(input bit p, input bit w, input logic [14:0] a,
                          input logic [7:0] d, input bit drop);
        exp_t e;
        bit   done = 0;
        @(negedge clk);
        chk("ack_clear", {31'b0, ack0 | ack1}, 0);
        w_cnt = 0; r_cnt = 0; oe_rd = 0;
        if (w) model[int'(a)] = d;
        sb.push_back('{p, w, w ? d : (model.exists(int'(a)) ? model[int'(a)] : 8'h00)});
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        for (int i = 1; i <= 12 && !done; i++) begin
            @(negedge clk);
            if (drop && i == 1) begin req0 = 0; req1 = 0; end
            if (ack0 | ack1) begin
                e = sb.pop_front();
                done = 1;
                chk("ack_one", 32'(ack0) + 32'(ack1), 1);
                chk("ack_port", {31'b0, ack1}, {31'b0, e.port});
                chk("ack_lat", i, 3);
                if (e.we) begin
                    chk("w_strobes", w_cnt, 1);
                    chk("w_no_read", r_cnt, 0);
                end else begin
                    chk("rdata", {24'b0, rdata}, {24'b0, e.data});
                    chk("r_strobes", r_cnt, 1);
                    chk("r_no_write", w_cnt, 0);
                    chk("r_oe_low", {31'b0, oe_rd}, 0);
                end
                req0 = 0; req1 = 0;
            end
        end
        if (!done) begin
            chk("ack_timeout", {31'b0, done}, 1);
            void'(sb.pop_front());
            req0 = 0; req1 = 0;
        end
    endtask

    initial begin
        exp_t e;
        int   n, last_t;
        #1;
        chk("rst_ram_r", {31'b0, ram_r}, 0);
        chk("rst_ram_w", {31'b0, ram_w}, 0);
        chk("rst_oe", {31'b0, ram_wdata_oe}, 0);
        chk("rst_acks", {30'b0, ack1, ack0}, 0);
        chk("rst_addr", {17'b0, ram_addr}, 0);
        chk("rst_wdata", {24'b0, ram_wdata}, 0);
        chk("rst_rdata", {24'b0, rdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        access(0, 1, 15'h1234, 8'hA5, 0);
        chk("mem_1234", {24'b0, mem[15'h1234]}, 32'hA5);
        access(1, 0, 15'h1234, 8'h00, 0);

        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        we0 = 0; addr0 = 15'h1234; we1 = 0; addr1 = 15'h0042;
        for (int k = 0; k < 4; k++)
            sb.push_back('{k[0], 1'b0, k[0] ? 8'h00 : 8'hA5});
        req0 = 1; req1 = 1;
        n = 0; last_t = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                e = sb.pop_front();
                chk("rr_one", 32'(ack0) + 32'(ack1), 1);
                chk("rr_port", {31'b0, ack1}, {31'b0, e.port});
                chk("rr_rdata", {24'b0, rdata}, {24'b0, e.data});
                if (n > 0) chk("rr_gap", c - last_t, 4);
                else chk("rr_lat", c, 3);
                last_t = c;
                n++;
            end
        end
        chk("rr_count", n, 4);
        sb.delete();
        req0 = 0; req1 = 0;

        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 15'h0200; wdata0 = 8'h3C;
        repeat (2) @(negedge clk);
        chk("rst_pre_w", {31'b0, ram_w}, 1);
        rst_n = 0;
        #1;
        chk("rst_async_w", {31'b0, ram_w}, 0);
        chk("rst_async_oe", {31'b0, ram_wdata_oe}, 0);
        chk("rst_async_ack", {31'b0, ack0}, 0);
        req0 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_ack", {30'b0, ack1, ack0}, 0);
            chk("rst_no_strobe", {30'b0, ram_r, ram_w}, 0);
        end
        access(0, 0, 15'h1234, 8'h00, 0);

        access(1, 1, 15'h0300, 8'h77, 1);
        access(0, 0, 15'h0300, 8'h00, 0);
        chk("mem_0300", {24'b0, mem[15'h0300]}, 32'h77);

        for (int k = 0; k < 1000; k++)
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   15'h0100 + 15'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 7) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (DMA/video); held high until matching ack.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; sampled with request at grant.
REQ-007 addr0, addr1  input  ADDR_W each  access address; sampled at grant.
REQ-008 wdata0, wdata1  input  DATA_W each  write data; sampled at grant.
REQ-009 ack0, ack1  output  1 each  one-cycle pulse marking access completion.
REQ-010 rdata  output  DATA_W  read data; valid in the ack cycle, held until the next read completes.
REQ-011 ram_addr  output  ADDR_W  address to RAM.
REQ-012 ram_wdata  output  DATA_W  data driven to the RAM data bus during writes.
REQ-013 ram_wdata_oe  output  1  tristate enable for ram_wdata onto the shared data bus.
REQ-014 ram_rdata  input  DATA_W  RAM data bus as read back.
REQ-015 ram_r, ram_w  output  1 each  RAM read/write strobes; RAM acts on the strobe's rising edge.

Function
REQ-016 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-017 IDLE: if any req high, grant per REQ-022, latch we/addr/wdata of the winner, go SETUP; otherwise stay.
REQ-018 SETUP (1 cycle): ram_addr and ram_wdata stable, ram_wdata_oe = latched we, strobes low; go STROBE.
REQ-019 STROBE (1 cycle): ram_w = we, ram_r = !we; address/data/oe unchanged; on exit edge capture ram_rdata into rdata if read; go HOLD.
REQ-020 HOLD (1 cycle): strobes low, address/data/oe unchanged; pulse ack of granted requester; go IDLE.
REQ-021 Latency: req seen in IDLE at edge N -> ack high in cycle N+3; one access per 4 cycles max.
REQ-022 Arbitration round-robin: on simultaneous requests, grant the requester not granted last; single request always granted.
REQ-023 ram_r and ram_w never both high; no strobe outside STROBE.
REQ-024 ram_wdata_oe low in IDLE and for reads; never high while ram_r high.
REQ-025 Requester dropping req before ack: access still completes and ack still pulses (no abort).
REQ-026 Requester re-asserting req in the ack cycle is treated as a new request in IDLE next cycle.
REQ-027 Address wrap not applicable; ram_addr is exactly the latched ADDR_W-bit address.

Reset
REQ-028 rst_n low: immediately (asynchronously) state = IDLE, ram_r = ram_w = 0, ram_wdata_oe = 0, ack0 = ack1 = 0.
REQ-029 Reset values: ram_addr = 0, ram_wdata = 0, rdata = 0, last-granted pointer = requester 1 (so requester 0 wins first tie).
REQ-030 Reset mid-access abandons the access with no ack; RAM contents unspecified for an interrupted write.

Structure
REQ-031 Shared package ram_pkg holds RAM_BUS_SIZE = 15, RAM data width 8, and the FSM state type.
REQ-032 One sub-module ram_rr_pick: combinational 2-way round-robin pick from req vector and last-grant pointer.
REQ-033 Tristate of the data bus lives at top level, not in this block.

Verification
REQ-034 Reset, then req0 write addr 0x1234 data 0xA5 -> ram_w high exactly one cycle, ack0 at N+3, RAM[0x1234] = 0xA5.
REQ-035 req1 read addr 0x1234 after REQ-034 -> ram_r one cycle, ack1 at N+3, rdata = 0xA5, oe low throughout.
REQ-036 req0 and req1 high together from reset, held continuously -> grants alternate 0,1,0,1, ack every 4 cycles.
REQ-037 rst_n low during STROBE of a write -> ram_w falls without clock edge, no ack, state IDLE after release.
REQ-038 Random mixed traffic 1000 accesses vs scoreboard model -> data matches, strobes never overlap, oe never high with ram_r.
